// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // Index of the hardwired PC slot; it has no storage behind it.
  function automatic int pc_idx(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sweep sequencer: walks every stored register once, after reset or on a clr pulse,
// emitting a zero-write strobe/address consumed by the register file write mux.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic         busy,
  output logic         clr_we,
  output logic [N-1:0] clr_addr
);

  // Last stored index; the PC slot above it is skipped.
  localparam logic [N-1:0] LAST_IDX = N'(pc_idx(N) - 1);

  rf_state_t    state_q, state_d;
  logic [N-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read, dual-write register file with write-through bypass, a hardwired PC slot
// and a hardware clear sweep that zeroes the array after reset or on request.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 32,
  parameter int R      = 3,
  parameter int BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           WE3,
  input  logic [N-1:0]   A3,
  input  logic [M-1:0]   WD3,
  input  logic           WE4,
  input  logic [N-1:0]   A4,
  input  logic [M-1:0]   WD4,
  input  logic [R*N-1:0] RA,
  input  logic [M-1:0]   R15,
  output logic [R*M-1:0] RD,
  output logic           busy,
  output logic           pc_wr_err
);

  localparam int           DEPTH   = pc_idx(N);
  localparam logic [N-1:0] PC_ADDR = N'(pc_idx(N));

  logic [M-1:0] mem_q [DEPTH];
  logic [M-1:0] mem_d [DEPTH];
  logic         pc_wr_err_q, pc_wr_err_d;
  logic         clr_we;
  logic [N-1:0] clr_addr;
  logic         wr_ok;

  regfile_clear_seq #(.N(N)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok = !busy && !rst;

  // Port 4 is applied first so port 3 wins on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (wr_ok) begin
      if (WE4 && A4 != PC_ADDR) mem_d[A4] = WD4;
      if (WE3 && A3 != PC_ADDR) mem_d[A3] = WD3;
    end
  end

  always_comb begin
    pc_wr_err_d = wr_ok && ((WE3 && A3 == PC_ADDR) || (WE4 && A4 == PC_ADDR));
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_wr_err_q <= 1'b0;
    else     pc_wr_err_q <= pc_wr_err_d;
  end

  assign pc_wr_err = pc_wr_err_q;

  for (genvar k = 0; k < R; k++) begin : g_rd
    logic [N-1:0] ra;
    logic [M-1:0] rd;

    assign ra = RA[k*N +: N];

    always_comb begin
      rd = '0;
      if (busy)                                     rd = '0;
      else if (ra == PC_ADDR)                       rd = R15;
      else if (BYPASS != 0 && WE3 && A3 == ra)      rd = WD3;
      else if (BYPASS != 0 && WE4 && A4 == ra)      rd = WD4;
      else                                          rd = mem_q[ra];
    end

    assign RD[k*M +: M] = rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed plus randomized checks of register_file_mp against a behavioural model.
module tb_register_file_mp;
  localparam int N = 4;
  localparam int M = 32;
  localparam int R = 3;
  localparam int PC = 15;
  localparam int WORDS = 15;

  logic           clk = 1'b0;
  logic           rst, clr, WE3, WE4;
  logic [N-1:0]   A3, A4;
  logic [M-1:0]   WD3, WD4, R15;
  logic [R*N-1:0] RA;
  logic [R*M-1:0] RD;
  logic           busy, pc_wr_err;

  register_file_mp #(.N(N), .M(M), .R(R), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .WE4(WE4), .A4(A4), .WD4(WD4),
    .RA(RA), .R15(R15), .RD(RD),
    .busy(busy), .pc_wr_err(pc_wr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: stored words, sweep position (-1 = not sweeping), expected error flag.
  logic [31:0] ref_mem [WORDS];
  int          sweep_pos = 0;
  logic        ref_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (sweep_pos >= 0) return 32'h0;
    if (int'(a) == PC) return R15;
    if (WE3 && A3 == a) return WD3;
    if (WE4 && A4 == a) return WD4;
    return ref_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      sweep_pos = 0;
      ref_err   = 1'b0;
    end else if (sweep_pos >= 0) begin
      ref_mem[sweep_pos] = 32'h0;
      sweep_pos++;
      if (sweep_pos == WORDS) sweep_pos = -1;
      ref_err = 1'b0;
    end else begin
      ref_err = (WE3 && int'(A3) == PC) || (WE4 && int'(A4) == PC);
      if (WE4 && int'(A4) != PC) ref_mem[A4] = WD4;
      if (WE3 && int'(A3) != PC) ref_mem[A3] = WD3;
      if (clr) sweep_pos = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    for (int k = 0; k < R; k++)
      chk($sformatf("%s_rd%0d", tag, k), RD[k*M +: M], exp_rd(RA[k*N +: N]));
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, (sweep_pos >= 0)});
    chk({tag, "_err"}, {31'b0, pc_wr_err}, {31'b0, ref_err});
  endtask

  task automatic idle_inputs();
    clr = 1'b0; WE3 = 1'b0; WE4 = 1'b0;
    A3 = '0; A4 = '0; WD3 = '0; WD4 = '0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); R15 = '0; RA = '0;

    // 1: reset and power-on sweep
    tick(); tick();
    check_all("rst");
    chk("rst_busy_const", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA = 12'($urandom);
      check_all("sweep1");
      chk("sweep1_busy_const", {31'b0, busy}, 32'd1);
      tick();
    end
    chk("sweep1_done", {31'b0, busy}, 32'd0);
    for (int a = 0; a < 15; a++) begin
      RA = {4'(a), 4'(a), 4'(a)};
      check_all("post_rst_zero");
    end

    // 2: bypass on port 3, then stored value
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'hDEADBEEF; RA = {4'd0, 4'd0, 4'd5};
    check_all("byp3");
    chk("byp3_const", RD[31:0], 32'hDEADBEEF);
    tick(); idle_inputs();
    check_all("st3");
    chk("st3_const", RD[31:0], 32'hDEADBEEF);

    // 3: same-address collision, port 3 wins
    WE3 = 1'b1; WE4 = 1'b1; A3 = 4'd7; A4 = 4'd7; WD3 = 32'h11; WD4 = 32'h22;
    RA = {4'd0, 4'd7, 4'd0};
    check_all("coll_byp");
    chk("coll_byp_const", RD[63:32], 32'h11);
    tick(); idle_inputs();
    check_all("coll_st");
    chk("coll_st_const", RD[63:32], 32'h11);

    // 4: write to PC slot
    WE4 = 1'b1; A4 = 4'd15; WD4 = 32'h55; R15 = 32'h1008; RA = {4'd0, 4'd15, 4'd0};
    check_all("pcw");
    chk("pcw_rd_const", RD[63:32], 32'h1008);
    tick(); idle_inputs();
    check_all("pcw_err");
    chk("pcw_err_const", {31'b0, pc_wr_err}, 32'd1);
    tick();
    check_all("pcw_err_gone");
    chk("pcw_err_gone_const", {31'b0, pc_wr_err}, 32'd0);
    chk("pcw_rd_later", RD[63:32], 32'h1008);

    // 5: writes dropped during a clr sweep
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hAB; RA = {4'd3, 4'd0, 4'd3};
    tick(); idle_inputs();
    check_all("pre_clr");
    chk("pre_clr_const", RD[31:0], 32'hAB);
    clr = 1'b1;
    tick(); clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hCD; end
      if (i == 4) begin WE4 = 1'b1; A4 = 4'd15; WD4 = 32'h77; clr = 1'b1; end
      check_all("sweep5");
      chk("sweep5_busy_const", {31'b0, busy}, 32'd1);
      tick(); idle_inputs();
    end
    check_all("post_clr");
    chk("post_clr_busy", {31'b0, busy}, 32'd0);
    chk("post_clr_a3", RD[31:0], 32'h0);

    // 6: reset in the middle of a clr sweep restarts it
    WE3 = 1'b1; A3 = 4'd9; WD3 = 32'h1234; tick(); idle_inputs();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA = 12'($urandom);
      check_all("sweep6");
      chk("sweep6_busy_const", {31'b0, busy}, 32'd1);
      tick();
    end
    chk("sweep6_done", {31'b0, busy}, 32'd0);
    for (int a = 0; a < 15; a++) begin
      RA = {4'(a), 4'(a), 4'(a)};
      check_all("post6");
      chk("post6_zero", RD[31:0], 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      WE3 = 1'($urandom_range(0, 1));
      WE4 = 1'($urandom_range(0, 1));
      A3  = 4'($urandom);
      A4  = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom);
      WD3 = $urandom;
      WD4 = $urandom;
      R15 = $urandom;
      clr = ($urandom_range(0, 39) == 0);
      RA  = ($urandom_range(0, 1) == 0) ? {A4, A3, 4'($urandom)} : 12'($urandom);
      check_all("rnd");
      tick();
    end
    idle_inputs();
    check_all("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Next-generation CPU register file. It has parameterised width, depth and read-port count. It adds:
- a second write port for base-register writeback,
- write-through bypass,
- a hardwired PC register slot,
- a hardware clear sequencer that zeroes the array after reset or on request.

It sits in the decode/writeback path of the CPU and replaces the single-write, uninitialised register file.

Parameters:
N, 4, address width; array holds 2**N registers; index 2**N-1 is the PC slot.
M, 32, data width in bits.
R, 3, number of read ports.
BYPASS, 1, 1 = a same-cycle write is visible on reads (write-through); 0 = reads return stored value only.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
clr  in  1  single-cycle request to start a clear sweep.
WE3  in  1  write enable, port 3 (primary writeback).
A3  in  N  write address, port 3.
WD3  in  M  write data, port 3.
WE4  in  1  write enable, port 4 (base/auxiliary writeback).
A4  in  N  write address, port 4.
WD4  in  M  write data, port 4.
RA  in  R*N  packed read addresses; slice k = port k.
R15  in  M  externally supplied PC value (already PC+8).
RD  out  R*M  packed read data; slice k = port k.
busy  out  1  high while the clear sweep runs.
pc_wr_err  out  1  registered one-cycle pulse: a write targeted the PC slot.

Behaviour:
- Clock is clk, single domain. Reset rst is synchronous, active-high; no asynchronous paths.
- Read path (combinational, zero latency), per port k, in priority order:
  1. busy=1: RD[k]=0.
  2. RA[k]==2**N-1: RD[k]=R15.
  3. BYPASS=1, WE3=1, A3==RA[k]: RD[k]=WD3.
  4. BYPASS=1, WE4=1, A4==RA[k]: RD[k]=WD4.
  5. Otherwise: RD[k]=mem[RA[k]].
- Write path: registered, one cycle; value is stored at the next rising edge.
- Writes to the PC slot (2**N-1) are never stored. In that case pc_wr_err=1 on the next cycle and is 0 otherwise.
- Both ports enabled with A3==A4 (not the PC slot): WD3 is stored, WD4 is dropped. The bypass obeys the same priority.
- Both ports enabled with different addresses: both are stored in the same cycle.
- State machine, states IDLE and CLEAR, with counter idx (N bits):
  - rst=1: state<=CLEAR, idx<=0, busy=1, pc_wr_err<=0.
  - IDLE, clr=1: next state CLEAR, idx<=0.
  - CLEAR: mem[idx]<=0, idx<=idx+1. When idx==2**N-2, state<=IDLE after that write.
  - Sweep length: 2**N-1 cycles. The PC slot is not cleared because it has no storage.
  - During CLEAR:
    - WE3 and WE4 are ignored and nothing from them is stored.
    - pc_wr_err stays 0.
    - clr is ignored.
  - rst asserted mid-sweep: restart from idx=0.
- busy is combinational from state (1 in CLEAR). It rises the cycle after rst or clr and falls the cycle after the last clear write.
- Reset values: busy=1, pc_wr_err=0, all RD=0 (busy forces them).
- Storage: 2**N-1 words of M bits. No storage is allocated for the PC slot.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} rf_state_t,
  - function pc_idx(N) returning 2**N-1.
- One sub-module, regfile_clear_seq. It contains the state register, idx counter, busy and the clear write strobe/address. The top-level write mux consumes these.
- The read-port mux is a generate loop over R in the top level.

Test Plan:
1. rst held 2 cycles, then released; N=4 -> busy=1 for 15 cycles after release, then 0. Every RA reads 0 during and after the sweep.
2. WE3=1, A3=5, WD3=0xDEADBEEF with RA[0]=5, BYPASS=1 -> RD[0]=0xDEADBEEF in the same cycle. The next cycle, with WE3=0, RD[0] still reads 0xDEADBEEF.
3. Same-cycle writes A3=A4=7, WD3=0x11, WD4=0x22 -> RD at address 7 reads 0x11 in the same cycle (bypass) and on the next cycle (stored).
4. WE4=1, A4=15, WD4=0x55; R15=0x1008; RA[1]=15 -> RD[1]=0x1008 and pc_wr_err=1 for exactly one cycle. A later read of address 15 still returns R15.
5. Write A3=3 with 0xAB, then pulse clr. During the sweep, issue WE3 to address 3 with 0xCD -> busy for 15 cycles, the write is dropped, and address 3 reads 0 after the sweep.
6. Pulse clr, assert rst at sweep cycle 6, then release -> busy remains high for a full 15 cycles counted from the rst release, and all registers read 0 afterwards.
